bram_cswap_ctrl: RTL and testbench

- Sequencer that owns both ports of the dual-port sort BRAM and performs one element-pair operation per request: read pair, unconditional swap, or compare-and-swap.
- Sits between the quicksort partition FSM and the dual-port BRAM (1-cycle registered read, read-first, per-port write enable).
- Gives the partition logic a single start/done handshake instead of raw port timing.

---
 rtl/bram_cswap_ctrl.sv | 125 ++++++++++++
 tb/tb_bram_cswap_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_cswap_ctrl.sv
// Element-pair sequencer for the dual-port sort BRAM: read pair, swap, or compare-and-swap.
// Owns both BRAM ports and presents a single start/done handshake to the partition FSM.
module bram_cswap_ctrl #(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr_i,
    input  logic [AW-1:0] addr_j,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] rdata_i,
    output logic [DW-1:0] rdata_j,
    output logic          swapped,
    output logic          bram_wea,
    output logic [AW-1:0] bram_addra,
    output logic [DW-1:0] bram_dina,
    input  logic [DW-1:0] bram_douta,
    output logic          bram_web,
    output logic [AW-1:0] bram_addrb,
    output logic [DW-1:0] bram_dinb,
    input  logic [DW-1:0] bram_doutb
);

    // state  | meaning
    // IDLE   | ready, waiting for start
    // RD     | addresses on both ports, BRAM registers read data
    // CMP    | capture read data, decide whether to write
    // WR     | crossed write on both ports in one edge
    // DONE   | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_SWAP  = 2'b01;
    localparam logic [1:0] OP_CSWAP = 2'b10;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    op_q;
    logic [AW-1:0] addr_i_q;
    logic [AW-1:0] addr_j_q;
    logic          gt;
    logic          do_wr;

    // Decision uses the live BRAM outputs; rdata_* only become valid after CMP.
    always_comb begin
        if (SIGNED_CMP)
            gt = $signed(bram_douta) > $signed(bram_doutb);
        else
            gt = bram_douta > bram_doutb;
    end

    always_comb begin
        do_wr = 1'b0;
        case (op_q)
            OP_SWAP:  do_wr = 1'b1;
            OP_CSWAP: do_wr = gt;
            default:  do_wr = 1'b0;
        endcase
        if (addr_i_q == addr_j_q)
            do_wr = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RD;
            S_RD:    state_nxt = S_CMP;
            S_CMP:   state_nxt = do_wr ? S_WR : S_DONE;
            S_WR:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= 2'b00;
            addr_i_q <= '0;
            addr_j_q <= '0;
            rdata_i  <= '0;
            rdata_j  <= '0;
            swapped  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op;
                        addr_i_q <= addr_i;
                        addr_j_q <= addr_j;
                    end
                end
                S_CMP: begin
                    rdata_i <= bram_douta;
                    rdata_j <= bram_doutb;
                    swapped <= 1'b0;
                end
                S_WR:    swapped <= 1'b1;
                default: ;
            endcase
        end
    end

    assign ready      = (state == S_IDLE);
    assign done       = (state == S_DONE);
    assign bram_addra = addr_i_q;
    assign bram_addrb = addr_j_q;
    // Gating with rst keeps a reset that lands in WR from corrupting memory.
    assign bram_wea   = (state == S_WR) && !rst;
    assign bram_web   = (state == S_WR) && !rst;
    assign bram_dina  = (state == S_WR) ? rdata_j : '0;
    assign bram_dinb  = (state == S_WR) ? rdata_i : '0;

endmodule

// File: tb/tb_bram_cswap_ctrl.sv
// Scoreboard bench: unsigned and signed controllers run the same directed vectors
// against private read-first BRAM models; a monitor checks each done pulse.
module tb_bram_cswap_ctrl;

    typedef struct packed {
        logic [1:0][15:0] rdi;
        logic [1:0][15:0] rdj;
        logic [1:0]       sw;
        logic [1:0][2:0]  lat;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic [17:0]      addr_i = '0;
    logic [17:0]      addr_j = '0;
    logic [1:0]       ready_v, done_v, sw_v, wea_v, web_v;
    logic [1:0][15:0] rdi_v, rdj_v, dina_v, dinb_v, douta_v, doutb_v;
    logic [1:0][17:0] addra_v, addrb_v;

    logic [15:0] mem [2][32];
    logic        pl_we = 1'b0;
    logic [4:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_done = 0;
    int   wa_cnt[2] = '{0, 0};
    int   wb_cnt[2] = '{0, 0};
    int   wa_mark[2] = '{0, 0};
    int   wb_mark[2] = '{0, 0};
    exp_t q0[$];
    exp_t q1[$];
    exp_t me;

    bram_cswap_ctrl #(.AW(18), .DW(16), .SIGNED_CMP(1'b0)) u_uns (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr_i(addr_i), .addr_j(addr_j),
        .ready(ready_v[0]), .done(done_v[0]), .rdata_i(rdi_v[0]), .rdata_j(rdj_v[0]),
        .swapped(sw_v[0]), .bram_wea(wea_v[0]), .bram_addra(addra_v[0]), .bram_dina(dina_v[0]),
        .bram_douta(douta_v[0]), .bram_web(web_v[0]), .bram_addrb(addrb_v[0]),
        .bram_dinb(dinb_v[0]), .bram_doutb(doutb_v[0])
    );

    bram_cswap_ctrl #(.AW(18), .DW(16), .SIGNED_CMP(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .start(start), .op(op), .addr_i(addr_i), .addr_j(addr_j),
        .ready(ready_v[1]), .done(done_v[1]), .rdata_i(rdi_v[1]), .rdata_j(rdj_v[1]),
        .swapped(sw_v[1]), .bram_wea(wea_v[1]), .bram_addra(addra_v[1]), .bram_dina(dina_v[1]),
        .bram_douta(douta_v[1]), .bram_web(web_v[1]), .bram_addrb(addrb_v[1]),
        .bram_dinb(dinb_v[1]), .bram_doutb(doutb_v[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first, one-cycle registered BRAM per controller, plus a bench preload port.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            douta_v[k] <= mem[k][addra_v[k][4:0]];
            doutb_v[k] <= mem[k][addrb_v[k][4:0]];
            if (pl_we) begin
                mem[k][pl_addr] <= pl_data;
            end else begin
                if (wea_v[k]) mem[k][addra_v[k][4:0]] <= dina_v[k];
                if (web_v[k]) mem[k][addrb_v[k][4:0]] <= dinb_v[k];
            end
            if (wea_v[k]) wa_cnt[k] <= wa_cnt[k] + 1;
            if (web_v[k]) wb_cnt[k] <= wb_cnt[k] + 1;
        end
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s dut%0d actual=%h required=%h at cycle %0d", name, k, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_v[k]) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    chk("unexpected_done", k, 32'd1, 32'd0);
                end else begin
                    if (k == 0) me = q0.pop_front();
                    else        me = q1.pop_front();
                    chk("rdata_i", k, 32'(rdi_v[k]), 32'(me.rdi[k]));
                    chk("rdata_j", k, 32'(rdj_v[k]), 32'(me.rdj[k]));
                    chk("swapped", k, 32'(sw_v[k]), 32'(me.sw[k]));
                    chk("latency", k, 32'(cyc - me.acc), 32'(me.lat[k]));
                    chk("wea_pulses", k, 32'(wa_cnt[k] - wa_mark[k]), 32'(me.sw[k]));
                    chk("web_pulses", k, 32'(wb_cnt[k] - wb_mark[k]), 32'(me.sw[k]));
                end
                wa_mark[k] = wa_cnt[k];
                wb_mark[k] = wb_cnt[k];
                last_done  = cyc;
            end
        end
    end

    function automatic exp_t mk(input logic [15:0] rdi0, rdj0, input logic sw0, input logic [2:0] lat0,
                                input logic [15:0] rdi1, rdj1, input logic sw1, input logic [2:0] lat1);
        exp_t e;
        e.rdi = {rdi1, rdi0};
        e.rdj = {rdj1, rdj0};
        e.sw  = {sw1, sw0};
        e.lat = {lat1, lat0};
        e.acc = 0;
        return e;
    endfunction

    task automatic poke(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Issues one request once both controllers are ready; optionally keeps start
    // high with a different request while the controllers are busy.
    task automatic issue(input logic [1:0] o, input logic [17:0] ai, input logic [17:0] aj,
                         input exp_t e_in, input bit push, input bit hold, input bit b2b);
        exp_t e;
        int   n;
        e = e_in;
        n = 0;
        @(negedge clk);
        while (ready_v != 2'b11 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 0, 32'(ready_v), 32'd3);
        if (b2b) chk("b2b_accept_cycle", 0, 32'(cyc), 32'(last_done + 1));
        start = 1'b1; op = o; addr_i = ai; addr_j = aj;
        e.acc = cyc;
        if (push) begin
            q0.push_back(e);
            q1.push_back(e);
        end
        @(negedge clk);
        if (hold) begin
            op = 2'b01; addr_i = 18'd3; addr_j = 18'd4;
            @(negedge clk);
            @(negedge clk);
        end
        start = 1'b0; op = 2'b00; addr_i = '0; addr_j = '0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        poke(5'd5, 16'h0030);
        poke(5'd9, 16'h0010);
        poke(5'd1, 16'hFFFF);
        poke(5'd2, 16'h0001);
        poke(5'd7, 16'h1234);
        poke(5'd3, 16'h0AAA);
        poke(5'd4, 16'h0BBB);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 32'(ready_v[k]), 32'd1);
            chk("rst_done", k, 32'(done_v[k]), 32'd0);
            chk("rst_swapped", k, 32'(sw_v[k]), 32'd0);
            chk("rst_rdata", k, {rdi_v[k], rdj_v[k]}, 32'd0);
            chk("rst_we", k, 32'({wea_v[k], web_v[k]}), 32'd0);
            chk("rst_addr", k, 32'(addra_v[k] | addrb_v[k]), 32'd0);
            chk("rst_din", k, {dina_v[k], dinb_v[k]}, 32'd0);
        end
        rst = 1'b0;

        // CSWAP out of order -> write; same pair again is now ordered.
        issue(2'b10, 18'd5, 18'd9, mk(16'h0030, 16'h0010, 1, 4, 16'h0030, 16'h0010, 1, 4), 1, 0, 0);
        issue(2'b10, 18'd5, 18'd9, mk(16'h0010, 16'h0030, 0, 3, 16'h0010, 16'h0030, 0, 3), 1, 0, 0);
        issue(2'b00, 18'd5, 18'd9, mk(16'h0010, 16'h0030, 0, 3, 16'h0010, 16'h0030, 0, 3), 1, 0, 0);
        // -1 vs 1: unsigned sees 0xFFFF > 1, signed does not.
        issue(2'b10, 18'd1, 18'd2, mk(16'hFFFF, 16'h0001, 1, 4, 16'hFFFF, 16'h0001, 0, 3), 1, 0, 0);
        issue(2'b00, 18'd1, 18'd2, mk(16'h0001, 16'hFFFF, 0, 3, 16'hFFFF, 16'h0001, 0, 3), 1, 0, 0);
        // Same-address SWAP must not write.
        issue(2'b01, 18'd7, 18'd7, mk(16'h1234, 16'h1234, 0, 3, 16'h1234, 16'h1234, 0, 3), 1, 0, 0);
        issue(2'b00, 18'd7, 18'd7, mk(16'h1234, 16'h1234, 0, 3, 16'h1234, 16'h1234, 0, 3), 1, 0, 0);
        // start held through RD/CMP with a SWAP 3/4 request: must be ignored.
        issue(2'b00, 18'd9, 18'd5, mk(16'h0030, 16'h0010, 0, 3, 16'h0030, 16'h0010, 0, 3), 1, 1, 0);
        // Back-to-back chain, each start in the cycle after done.
        issue(2'b01, 18'd5, 18'd9, mk(16'h0010, 16'h0030, 1, 4, 16'h0010, 16'h0030, 1, 4), 1, 0, 1);
        issue(2'b00, 18'd5, 18'd9, mk(16'h0030, 16'h0010, 0, 3, 16'h0030, 16'h0010, 0, 3), 1, 0, 1);
        issue(2'b10, 18'd9, 18'd5, mk(16'h0010, 16'h0030, 0, 3, 16'h0010, 16'h0030, 0, 3), 1, 0, 1);
        issue(2'b11, 18'd5, 18'd9, mk(16'h0030, 16'h0010, 0, 3, 16'h0030, 16'h0010, 0, 3), 1, 0, 1);

        // Reset landing in WR of SWAP 3/4: no write, no done.
        issue(2'b01, 18'd3, 18'd4, mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("in_wr_before_rst", k, 32'({wea_v[k], web_v[k]}), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("post_rst_ready", k, 32'(ready_v[k]), 32'd1);
            chk("post_rst_done", k, 32'(done_v[k]), 32'd0);
            chk("post_rst_no_write", k, 32'(wa_cnt[k] + wb_cnt[k]), 32'(wa_mark[k] + wb_mark[k]));
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("post_rst_idle", k, 32'({ready_v[k], done_v[k]}), 32'd2);
        issue(2'b00, 18'd3, 18'd4, mk(16'h0AAA, 16'h0BBB, 0, 3, 16'h0AAA, 16'h0BBB, 0, 3), 1, 0, 0);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drain", 0, 32'(q0.size()), 32'd0);
        chk("queue_drain", 1, 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
